audio_minmax_stream: RTL and testbench



---
 rtl/audio_stat_pkg.sv | 17 +
 rtl/minmax_lane.sv | 55 +++++
 rtl/audio_minmax_stream.sv | 155 +++++++++++++++
 tb/tb_audio_minmax_stream.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stat_pkg.sv
// Shared definitions for the audio min/max statistics stream: FSM state encoding
// and default widths used by the stream block and its per-channel lanes.
package audio_stat_pkg;

  localparam int DEF_SAMPLE_W = 32;
  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_LEN_W    = 16;
  localparam int DEF_IDX_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/minmax_lane.sv
// One channel's running minimum/maximum tracker. A beat with init set restarts
// the interval; later beats replace min/max only on a strict improvement.
module minmax_lane #(
  parameter int SAMPLE_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                init,
  input  logic                update_en,
  input  logic                signed_mode,
  output logic [SAMPLE_W-1:0] min,
  output logic [SAMPLE_W-1:0] max
);

  logic [SAMPLE_W-1:0] min_q, min_d;
  logic [SAMPLE_W-1:0] max_q, max_d;
  logic                lt_min, gt_max;

  // NOTE: every signal assigned in always_comb gets a default at the top so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lt_min = 1'b0;
    gt_max = 1'b0;
    min_d  = min_q;
    max_d  = max_q;
    if (signed_mode) begin
      lt_min = $signed(sample) < $signed(min_q);
      gt_max = $signed(sample) > $signed(max_q);
    end else begin
      lt_min = sample < min_q;
      gt_max = sample > max_q;
    end
    if (update_en) begin
      if (init || lt_min) min_d = sample;
      if (init || gt_max) max_d = sample;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min = min_q;
  assign max = max_q;

endmodule

// File: rtl/audio_minmax_stream.sv
// Streams multi-channel audio beats and reports per-channel min/max for each
// fixed-length interval; a run ends with the beat flagged in_last.
module audio_minmax_stream
  import audio_stat_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [LEN_W-1:0]           interval_len,
  input  logic                       signed_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*SAMPLE_W-1:0] out_max,
  output logic [NUM_CH*SAMPLE_W-1:0] out_min,
  output logic [IDX_W-1:0]           out_index,
  output logic                       out_partial,
  output logic                       busy,
  output logic                       done
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             signed_q, signed_d;
  logic             partial_q, partial_d;
  logic             last_q, last_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             at_last_cnt;

  assign accept      = in_valid && in_ready_q;
  assign at_last_cnt = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    signed_d  = signed_q;
    partial_d = partial_q;
    last_d    = last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A zero length would never close an interval, so it behaves as 1.
          len_d     = (interval_len == '0) ? LEN_W'(1) : interval_len;
          signed_d  = signed_mode;
          cnt_d     = '0;
          idx_d     = '0;
          partial_d = 1'b0;
          last_d    = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (at_last_cnt || in_last) begin
            partial_d = in_last && !at_last_cnt;
            last_d    = in_last;
            state_d   = ST_EMIT;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          idx_d     = idx_q + IDX_W'(1);
          cnt_d     = '0;
          partial_d = 1'b0;
          state_d   = last_q ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake/status outputs are registered copies of the next state.
    in_ready_d  = (state_d == ST_RUN);
    out_valid_d = (state_d == ST_EMIT);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_q       <= LEN_W'(1);
      cnt_q       <= '0;
      idx_q       <= '0;
      signed_q    <= 1'b0;
      partial_q   <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      signed_q    <= signed_d;
      partial_q   <= partial_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Lane registers only move on accepted beats, so they hold steady in EMIT.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    minmax_lane #(
      .SAMPLE_W (SAMPLE_W)
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample      (in_data[c*SAMPLE_W +: SAMPLE_W]),
      .init        (cnt_q == '0),
      .update_en   (accept),
      .signed_mode (signed_q),
      .min         (out_min[c*SAMPLE_W +: SAMPLE_W]),
      .max         (out_max[c*SAMPLE_W +: SAMPLE_W])
    );
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_index   = idx_q;
  assign out_partial = partial_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_audio_minmax_stream.sv
// Randomized bench for audio_minmax_stream: beats are chunked into intervals by
// a queue-based reference model and every emitted result is compared to it.
module tb_audio_minmax_stream;

  localparam int SW = 32;
  localparam int NC = 2;
  localparam int LW = 16;
  localparam int IW = 16;
  localparam int BW = SW * NC;

  typedef logic [BW-1:0] beat_t;
  typedef struct {
    beat_t          mx;
    beat_t          mn;
    logic [IW-1:0]  idx;
    logic           partial;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [LW-1:0] interval_len;
  logic          signed_mode;
  logic          in_valid;
  logic          in_ready;
  beat_t         in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  beat_t         out_max;
  beat_t         out_min;
  logic [IW-1:0] out_index;
  logic          out_partial;
  logic          busy;
  logic          done;

  audio_minmax_stream #(
    .SAMPLE_W (SW),
    .NUM_CH   (NC),
    .LEN_W    (LW),
    .IDX_W    (IW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .interval_len (interval_len),
    .signed_mode  (signed_mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_max      (out_max),
    .out_min      (out_min),
    .out_index    (out_index),
    .out_partial  (out_partial),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exp_q[$];
  beat_t beats[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_emit;
  beat_t last_max, last_min;
  logic  last_partial;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit less(input logic [SW-1:0] a, input logic [SW-1:0] b, input bit sm);
    if (sm) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // Reference: cut the beat list into chunks of len (0 means 1); the final
  // chunk may be short, which is exactly a partial interval.
  function automatic void build_model(input int len, input bit sm);
    int            eff;
    int            stop;
    exp_t          e;
    logic [SW-1:0] s, mx, mn;
    eff = (len == 0) ? 1 : len;
    exp_q.delete();
    for (int base = 0; base < beats.size(); base += eff) begin
      stop = (base + eff < beats.size()) ? base + eff : beats.size();
      for (int c = 0; c < NC; c++) begin
        mx = beats[base][c*SW +: SW];
        mn = mx;
        for (int i = base + 1; i < stop; i++) begin
          s = beats[i][c*SW +: SW];
          if (less(s, mn, sm)) mn = s;
          if (less(mx, s, sm)) mx = s;
        end
        e.mx[c*SW +: SW] = mx;
        e.mn[c*SW +: SW] = mn;
      end
      e.idx     = IW'(exp_q.size());
      e.partial = (stop - base) < eff;
      exp_q.push_back(e);
    end
  endfunction

  function automatic logic [SW-1:0] rand_sample();
    if ($urandom_range(2) == 0) return SW'($urandom_range(4)) - SW'(2);
    return $urandom;
  endfunction

  task automatic make_beats(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back({rand_sample(), rand_sample()});
  endtask

  // Run one stream; all driving and sampling happens on the falling edge.
  task automatic do_run(input int len, input bit sm, input int stall_first,
                        input int pv, input int pr);
    int bi, emit_cyc, cyc;
    bit got_done;
    build_model(len, sm);
    n_emit = 0;
    @(negedge clk);
    start        = 1'b1;
    interval_len = LW'(len);
    signed_mode  = sm;
    @(negedge clk);
    start        = 1'b0;
    interval_len = LW'($urandom);
    signed_mode  = $urandom_range(1);
    check("busy_after_start", busy, 1);
    bi = 0; emit_cyc = 0; cyc = 0; got_done = 0;
    while (!got_done && cyc < 3000) begin
      if (done) begin
        got_done = 1;
        check("done_all_beats", bi, beats.size());
        check("done_all_intervals", exp_q.size(), 0);
      end
      if (out_valid) begin
        check("in_ready_in_emit", in_ready, 0);
        if (exp_q.size() == 0) begin
          check("extra_output", out_valid, 0);
          out_ready = 1'b1;
        end else begin
          check("out_max", out_max, exp_q[0].mx);
          check("out_min", out_min, exp_q[0].mn);
          check("out_index", out_index, exp_q[0].idx);
          check("out_partial", out_partial, exp_q[0].partial);
          out_ready = (emit_cyc >= stall_first) && ($urandom_range(99) < pr);
          emit_cyc++;
          if (out_ready) begin
            last_max     = out_max;
            last_min     = out_min;
            last_partial = out_partial;
            n_emit++;
            emit_cyc = 0;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        out_ready = $urandom_range(1);
      end
      if (bi < beats.size()) begin
        in_valid = ($urandom_range(99) < pv);
        in_data  = beats[bi];
        in_last  = (bi == beats.size() - 1);
        if (in_valid && in_ready) bi++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("run_finished", got_done, 1);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    logic [SW-1:0] m5, m3;
    reset_n = 1'b0; start = 1'b0; interval_len = '0; signed_mode = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {in_ready, out_valid, out_partial, done, busy}, 0);
    check("rst_max_min", {out_max | out_min}, 0);
    check("rst_index", out_index, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Signed, len 4: ch0 5,-3,7,0.
    m5 = 32'd5; m3 = -32'sd3;
    beats.delete();
    beats.push_back({rand_sample(), m5});
    beats.push_back({rand_sample(), m3});
    beats.push_back({rand_sample(), 32'd7});
    beats.push_back({rand_sample(), 32'd0});
    do_run(4, 1'b1, 0, 100, 100);
    check("signed_max0", last_max[SW-1:0], 32'd7);
    check("signed_min0", last_min[SW-1:0], 32'hFFFFFFFD);
    check("signed_partial", last_partial, 0);
    check("signed_emits", n_emit, 1);

    // Same beats, unsigned compare.
    do_run(4, 1'b0, 0, 100, 100);
    check("unsigned_max0", last_max[SW-1:0], 32'hFFFFFFFD);
    check("unsigned_min0", last_min[SW-1:0], 32'd0);

    // len 3, 7 beats: two full intervals then a one-beat partial.
    make_beats(7);
    do_run(3, 1'b1, 0, 70, 70);
    check("len3_emits", n_emit, 3);
    check("len3_last_partial", last_partial, 1);
    check("len3_last_max", last_max, beats[6]);
    check("len3_last_min", last_min, beats[6]);

    // Consumer stalls 5 cycles on every result.
    make_beats(9);
    do_run(4, 1'b0, 5, 100, 100);
    check("stall_emits", n_emit, 3);

    // Zero length: each beat is its own interval.
    make_beats(5);
    do_run(0, 1'b1, 0, 80, 80);
    check("len0_emits", n_emit, 5);

    for (int r = 0; r < 6; r++) begin
      make_beats($urandom_range(20, 1));
      do_run($urandom_range(6, 1), $urandom_range(1), $urandom_range(2),
             $urandom_range(100, 30), $urandom_range(100, 30));
    end

    // Reset mid-interval, then a fresh len 2 run.
    @(negedge clk);
    start = 1'b1; interval_len = LW'(4); signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = {rand_sample(), rand_sample()}; in_last = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_state", {in_ready, out_valid, out_partial, done, busy}, 0);
    check("midrst_max_min", {out_max | out_min}, 0);
    check("midrst_index", out_index, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", {in_ready, out_valid, busy, done}, 0);
    make_beats(3);
    do_run(2, 1'b0, 0, 100, 100);
    check("post_rst_emits", n_emit, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
